// File: rtl/mem_stall_pkg.sv
// Shared types and constants for the stall/done memory responder.
package mem_stall_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } resp_state_t;

   localparam logic [15:0] LFSR_SEED     = 16'hACE1;
   // Fibonacci taps 16,14,13,11 expressed as zero-based bit positions 15,13,12,10.
   localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;
   localparam int          MAX_LATENCY   = 15;

   // Maps four pseudo-random bits onto an effective latency in 1..latency.
   function automatic logic [3:0] rand_latency(input logic [3:0] lfsr_low, input int latency);
      int lat_v;
      lat_v = 1 + (int'(lfsr_low) % latency);
      return 4'(lat_v);
   endfunction

endpackage

// File: rtl/mem_stall_responder_lfsr16.sv
// 16-bit Fibonacci LFSR used to randomise responder latency.
module lfsr16
   import mem_stall_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic [15:0] value
);

   logic [15:0] lfsr_r;
   logic        fb_s;

   // Feedback is the XOR of the tapped bits.
   always_comb begin
      fb_s = ^(lfsr_r & LFSR_TAP_MASK);
   end

   // Shift register, reseeded on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_r <= LFSR_SEED;
      end else if (enable) begin
         lfsr_r <= {lfsr_r[14:0], fb_s};
      end else begin
         lfsr_r <= lfsr_r;
      end
   end

   assign value = lfsr_r;

endmodule

// File: rtl/mem_stall_responder.sv
// Memory-side responder for the stall/done handshake: one request at a time, done after LATENCY cycles.
// Define MEM_STALL_RESP_RANDOM_LAT_EN to draw a per-request latency in 1..LATENCY from an LFSR.
module mem_stall_responder
   import mem_stall_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic              busy
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   resp_state_t           state_r, state_nxt_s;
   logic [3:0]            cnt_r, cnt_nxt_s, lat_s;
   logic                  capture_s, commit_s;
   logic                  wr_r, commit_wr_s;
   logic [DEPTH_LOG2-1:0] idx_r, req_idx_s, commit_idx_s;
   logic [DATA_W-1:0]     wdata_r, commit_wdata_s;
   logic [DATA_W-1:0]     rdata_r;
   logic                  done_r, busy_r;
   logic [DATA_W-1:0]     mem_r [DEPTH];
   logic                  unused_addr_s;

   // Byte-offset and high address bits are dropped, so storage aliases.
   assign req_idx_s     = req_addr[DEPTH_LOG2+1:2];
   assign unused_addr_s = ^{req_addr[1:0], req_addr[ADDR_W-1:DEPTH_LOG2+2]};

`ifdef MEM_STALL_RESP_RANDOM_LAT_EN
   logic [15:0] lfsr_s;
   logic        unused_lfsr_s;

   lfsr16 u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .enable (1'b1),
      .value  (lfsr_s)
   );

   assign lat_s         = rand_latency(lfsr_s[3:0], LATENCY);
   assign unused_lfsr_s = ^lfsr_s[15:4];
`else
   assign lat_s = 4'(LATENCY);
`endif

   // Next-state and commit decision.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      capture_s   = 1'b0;
      commit_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (req) begin
               capture_s = 1'b1;
               cnt_nxt_s = lat_s - 4'd1;
               if (lat_s == 4'd1) begin
                  state_nxt_s = RESP;
                  commit_s    = 1'b1;
               end else begin
                  state_nxt_s = WAIT;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT: begin
            cnt_nxt_s = cnt_r - 4'd1;
            if (cnt_r == 4'd1) begin
               state_nxt_s = RESP;
               commit_s    = 1'b1;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         RESP: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // With single-cycle latency the commit happens on the acceptance edge, so use live inputs.
   always_comb begin
      commit_wr_s    = wr_r;
      commit_idx_s   = idx_r;
      commit_wdata_s = wdata_r;
      if (state_r == IDLE) begin
         commit_wr_s    = req_write;
         commit_idx_s   = req_idx_s;
         commit_wdata_s = req_wdata;
      end else begin
         commit_wr_s    = wr_r;
         commit_idx_s   = idx_r;
         commit_wdata_s = wdata_r;
      end
   end

   // Control state, captured request fields and registered handshake outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= 4'd0;
         wr_r    <= 1'b0;
         idx_r   <= '0;
         wdata_r <= '0;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         if (capture_s) begin
            wr_r    <= req_write;
            idx_r   <= req_idx_s;
            wdata_r <= req_wdata;
         end
         done_r <= (state_nxt_s == RESP);
         busy_r <= (state_nxt_s != IDLE);
      end
   end

   // Read data returns the pre-write word on writes and holds until the next commit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_r <= '0;
      end else if (commit_s) begin
         rdata_r <= mem_r[commit_idx_s];
      end
   end

   // Storage is deliberately not reset; a commit coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (commit_s && commit_wr_s && !reset) begin
         mem_r[commit_idx_s] <= commit_wdata_s;
      end
   end

   assign rdata = rdata_r;
   assign done  = done_r;
   assign busy  = busy_r;

endmodule
